// File: rtl/multi_dispatcher.sv
// Dispatches the head-of-queue ticket to one free, open service counter per grant,
// using fixed-priority or round-robin arbitration. Optional grant counter: DISPATCH_STATS_EN.
module multi_dispatcher #(
  parameter int NUM_W   = 4,
  parameter int TIME_W  = 4,
  parameter int NUM_CNT = 3,
  parameter int RR_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      empty,
  input  logic [NUM_W-1:0]          qn_in,
  input  logic [TIME_W-1:0]         qt_in,
  input  logic [NUM_CNT-1:0]        busy_in,
  input  logic [NUM_CNT-1:0]        open_in,
  output logic                      re_out,
  output logic [NUM_CNT-1:0]        ld_out,
  output logic [NUM_CNT*NUM_W-1:0]  dn_out,
  output logic [NUM_CNT*TIME_W-1:0] dt_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]               grant_cnt
`endif
);

  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          last_idx;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_vld;
  logic [NUM_CNT-1:0]        eligible;
  logic [NUM_CNT-1:0]        ld_nxt;
  logic [NUM_CNT*NUM_W-1:0]  dn_nxt;
  logic [NUM_CNT*TIME_W-1:0] dt_nxt;

  assign eligible = ~busy_in & open_in;

  // NOTE: every signal written here gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    state_nxt = state;
    grant_vld = 1'b0;
    grant_idx = '0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          // Scan NUM_CNT candidates starting at 0 (fixed) or last+1 (round-robin).
          for (int i = 0; i < NUM_CNT; i++) begin
            cand = (IDX_W+1)'(i);
            if (RR_MODE != 0)
              cand = cand + {1'b0, last_idx} + (IDX_W+1)'(1);
            if (cand >= (IDX_W+1)'(NUM_CNT))
              cand = cand - (IDX_W+1)'(NUM_CNT);
            if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
              grant_vld = 1'b1;
              grant_idx = cand[IDX_W-1:0];
            end
          end
        end
        if (grant_vld)
          state_nxt = HOLD;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_nxt = '0;
    dn_nxt = '0;
    dt_nxt = '0;
    if (grant_vld) begin
      ld_nxt[grant_idx]                   = 1'b1;
      dn_nxt[grant_idx*NUM_W +: NUM_W]    = qn_in;
      dt_nxt[grant_idx*TIME_W +: TIME_W]  = qt_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_idx <= IDX_W'(NUM_CNT - 1);
    end else begin
      state <= state_nxt;
      if (grant_vld)
        last_idx <= grant_idx;
    end
  end

  // Outputs are registered, so a grant decided at edge N is visible for exactly
  // the cycle after it; the HOLD cycle that follows clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_out <= 1'b0;
      ld_out <= '0;
      dn_out <= '0;
      dt_out <= '0;
    end else begin
      re_out <= grant_vld;
      ld_out <= ld_nxt;
      dn_out <= dn_nxt;
      dt_out <= dt_nxt;
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      grant_cnt <= '0;
    else if (grant_vld && grant_cnt != 16'hFFFF)
      grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multi_dispatcher.sv
// Directed bench for multi_dispatcher: fixed-priority and round-robin instances
// driven from the same stimulus, with hand-computed expected outputs.
module tb_multi_dispatcher;

  logic       clk;
  logic       rst;
  logic       empty;
  logic [3:0] qn_in;
  logic [3:0] qt_in;
  logic [2:0] busy_in;
  logic [2:0] open_in;

  logic        fp_re, rr_re;
  logic [2:0]  fp_ld, rr_ld;
  logic [11:0] fp_dn, rr_dn;
  logic [11:0] fp_dt, rr_dt;
`ifdef DISPATCH_STATS_EN
  logic [15:0] fp_cnt, rr_cnt;
`endif

  int vectors;
  int miscompares;

  multi_dispatcher #(.NUM_W(4), .TIME_W(4), .NUM_CNT(3), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .empty(empty), .qn_in(qn_in), .qt_in(qt_in),
    .busy_in(busy_in), .open_in(open_in),
    .re_out(fp_re), .ld_out(fp_ld), .dn_out(fp_dn), .dt_out(fp_dt)
`ifdef DISPATCH_STATS_EN
    , .grant_cnt(fp_cnt)
`endif
  );

  multi_dispatcher #(.NUM_W(4), .TIME_W(4), .NUM_CNT(3), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .empty(empty), .qn_in(qn_in), .qt_in(qt_in),
    .busy_in(busy_in), .open_in(open_in),
    .re_out(rr_re), .ld_out(rr_ld), .dn_out(rr_dn), .dt_out(rr_dt)
`ifdef DISPATCH_STATS_EN
    , .grant_cnt(rr_cnt)
`endif
  );

  wire [27:0] fp_obs = {fp_re, fp_ld, fp_dn, fp_dt};
  wire [27:0] rr_obs = {rr_re, rr_ld, rr_dn, rr_dt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {re, ld, dn, dt}; k < 0 means no grant this cycle.
  function automatic logic [27:0] exp_vec(input int k, input logic [3:0] qn, input logic [3:0] qt);
    logic [2:0]  ld;
    logic [11:0] dn;
    logic [11:0] dt;
    ld = '0;
    dn = '0;
    dt = '0;
    if (k >= 0) begin
      ld[k]       = 1'b1;
      dn[k*4 +: 4] = qn;
      dt[k*4 +: 4] = qt;
    end
    return {(k >= 0), ld, dn, dt};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (fp_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_fp: got %h expected %h", fp_obs, 28'h0);
    end
    vectors++;
    if (rr_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_rr: got %h expected %h", rr_obs, 28'h0);
    end
    // Requests while held in reset must not grant.
    empty   = 1'b0;
    open_in = 3'b111;
    busy_in = 3'b000;
    qn_in   = 4'd2;
    qt_in   = 4'd4;
    tick();
    vectors++;
    if (fp_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_hold_fp: got %h expected %h", fp_obs, 28'h0);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (fp_obs !== exp_vec(0, 4'd2, 4'd4)) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %h expected %h", fp_obs, exp_vec(0, 4'd2, 4'd4));
    end
    empty = 1'b1;
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b0;
    qn_in   = 4'd5;
    qt_in   = 4'd9;
    tick();
    vectors++;
    if (fp_obs !== exp_vec(0, 4'd5, 4'd9)) begin
      miscompares++;
      $display("FAIL fixed_grant: got %h expected %h", fp_obs, exp_vec(0, 4'd5, 4'd9));
    end
    tick();
    vectors++;
    if (fp_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL fixed_quiet: got %h expected %h", fp_obs, 28'h0);
    end
    empty = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b0;
    for (int g = 0; g < 4; g++) begin
      qn_in = 4'(g + 1);
      qt_in = 4'(15 - g);
      tick();
      vectors++;
      if (rr_obs !== exp_vec(g % 3, 4'(g + 1), 4'(15 - g))) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %h expected %h", g, rr_obs, exp_vec(g % 3, 4'(g + 1), 4'(15 - g)));
      end
      vectors++;
      if (fp_obs !== exp_vec(0, 4'(g + 1), 4'(15 - g))) begin
        miscompares++;
        $display("FAIL fp_repeat%0d: got %h expected %h", g, fp_obs, exp_vec(0, 4'(g + 1), 4'(15 - g)));
      end
      tick();
      vectors++;
      if (rr_obs !== 28'h0) begin
        miscompares++;
        $display("FAIL rr_quiet%0d: got %h expected %h", g, rr_obs, 28'h0);
      end
    end
    empty = 1'b1;
    tick();
  endtask

  task automatic test_empty_gating();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({fp_re, rr_re} !== 2'b00) begin
        miscompares++;
        $display("FAIL empty_block%0d: got re %b expected 00", c, {fp_re, rr_re});
      end
    end
    empty = 1'b0;
    qn_in = 4'hA;
    qt_in = 4'hB;
    tick();
    vectors++;
    if (fp_obs !== exp_vec(0, 4'hA, 4'hB)) begin
      miscompares++;
      $display("FAIL empty_release_fp: got %h expected %h", fp_obs, exp_vec(0, 4'hA, 4'hB));
    end
    vectors++;
    if (rr_obs !== exp_vec(0, 4'hA, 4'hB)) begin
      miscompares++;
      $display("FAIL empty_release_rr: got %h expected %h", rr_obs, exp_vec(0, 4'hA, 4'hB));
    end
    empty = 1'b1;
    tick();
  endtask

  task automatic test_skip_ineligible();
    // RR pointer is at 0 here; counter 1 is closed and 0 busy, so both pick 2.
    busy_in = 3'b001;
    open_in = 3'b101;
    empty   = 1'b0;
    qn_in   = 4'd3;
    qt_in   = 4'd7;
    tick();
    vectors++;
    if (fp_obs !== exp_vec(2, 4'd3, 4'd7)) begin
      miscompares++;
      $display("FAIL skip_fp: got %h expected %h", fp_obs, exp_vec(2, 4'd3, 4'd7));
    end
    vectors++;
    if (rr_obs !== exp_vec(2, 4'd3, 4'd7)) begin
      miscompares++;
      $display("FAIL skip_rr: got %h expected %h", rr_obs, exp_vec(2, 4'd3, 4'd7));
    end
    empty = 1'b1;
    tick();
    open_in = 3'b001;
    empty   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({fp_obs, rr_obs} !== 56'h0) begin
        miscompares++;
        $display("FAIL none_eligible%0d: got fp %h rr %h expected 0", c, fp_obs, rr_obs);
      end
    end
    empty = 1'b1;
    tick();
  endtask

  task automatic test_hold_ignores_inputs();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b0;
    qn_in   = 4'd1;
    qt_in   = 4'd2;
    tick();
    vectors++;
    if (fp_obs !== exp_vec(0, 4'd1, 4'd2)) begin
      miscompares++;
      $display("FAIL hold_grant: got %h expected %h", fp_obs, exp_vec(0, 4'd1, 4'd2));
    end
    // Inputs changed while in HOLD: counter 0 becomes busy, others stay eligible.
    busy_in = 3'b001;
    qn_in   = 4'd8;
    tick();
    vectors++;
    if (fp_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL hold_quiet: got %h expected %h", fp_obs, 28'h0);
    end
    tick();
    vectors++;
    if (fp_obs !== exp_vec(1, 4'd8, 4'd2)) begin
      miscompares++;
      $display("FAIL hold_next_grant: got %h expected %h", fp_obs, exp_vec(1, 4'd8, 4'd2));
    end
    busy_in = 3'b000;
    empty   = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b0;
    qn_in   = 4'd6;
    qt_in   = 4'd6;
    tick();
    tick();
    tick();
    vectors++;
    if (rr_obs !== exp_vec(1, 4'd6, 4'd6)) begin
      miscompares++;
      $display("FAIL mid_pulse_pre: got %h expected %h", rr_obs, exp_vec(1, 4'd6, 4'd6));
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({fp_obs, rr_obs} !== 56'h0) begin
      miscompares++;
      $display("FAIL mid_pulse_abort: got fp %h rr %h expected 0", fp_obs, rr_obs);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++;
    if (rr_obs !== exp_vec(0, 4'd6, 4'd6)) begin
      miscompares++;
      $display("FAIL mid_pulse_restart: got %h expected %h", rr_obs, exp_vec(0, 4'd6, 4'd6));
    end
    empty = 1'b1;
    tick();
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    do_reset();
    busy_in = 3'b000;
    open_in = 3'b111;
    empty   = 1'b0;
    for (int g = 0; g < 7; g++) begin
      tick();
      tick();
    end
    empty = 1'b1;
    tick();
    vectors++;
    if (fp_cnt !== 16'd7) begin
      miscompares++;
      $display("FAIL stats_count: got %0d expected 7", fp_cnt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (fp_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got %0d expected 0", fp_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    empty   = 1'b1;
    qn_in   = '0;
    qt_in   = '0;
    busy_in = '0;
    open_in = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_empty_gating();
    test_skip_ineligible();
    test_hold_ignores_inputs();
    test_reset_mid_pulse();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_dispatcher.md
MULTI_DISPATCHER -- requirements
Module: multi_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_W, default 4, meaning ticket-number width.
REQ-002 The block SHALL have parameter TIME_W, default 4, meaning service-time width.
REQ-003 The block SHALL have parameter NUM_CNT, default 3, range 1..16, meaning counter count.
REQ-004 The block SHALL have parameter RR_MODE, default 0, where 0 selects fixed priority (lowest index first) and 1 selects round-robin.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port empty, input, 1 bit: queue FIFO empty flag.
REQ-008 The block SHALL have port qn_in, input, NUM_W bits: head-of-queue ticket number.
REQ-009 The block SHALL have port qt_in, input, TIME_W bits: head-of-queue service time.
REQ-010 The block SHALL have port busy_in, input, NUM_CNT bits: counter k is serving when bit k is 1.
REQ-011 The block SHALL have port open_in, input, NUM_CNT bits: counter k accepts customers when bit k is 1.
REQ-012 The block SHALL have port re_out, output, 1 bit: FIFO read-enable pulse.
REQ-013 The block SHALL have port ld_out, output, NUM_CNT bits: one-hot load pulse to counter k.
REQ-014 The block SHALL have port dn_out, output, NUM_CNT*NUM_W bits: ticket for counter k in slice [k*NUM_W +: NUM_W].
REQ-015 The block SHALL have port dt_out, output, NUM_CNT*TIME_W bits: time for counter k in slice [k*TIME_W +: TIME_W].

Function
REQ-016 Counter k SHALL be eligible when busy_in[k]=0 and open_in[k]=1.
REQ-017 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-018 In IDLE with empty=0 and at least one eligible counter, the block SHALL grant exactly one counter and go to HOLD.
REQ-019 When no grant is made in IDLE, the block SHALL stay in IDLE with all outputs 0.
REQ-020 HOLD SHALL last exactly one cycle, make no grant, and return to IDLE.
REQ-021 Grant latency SHALL be 1 cycle: inputs are sampled at edge N, and re_out=1, ld_out[k]=1, and slice k of dn_out/dt_out equal to the sampled qn_in/qt_in are all valid for the one cycle after edge N.
REQ-022 Throughput SHALL be at most one grant per 2 cycles.
REQ-023 re_out and ld_out SHALL be single-cycle pulses, and ld_out SHALL be one-hot or zero.
REQ-024 re_out SHALL be 1 if and only if ld_out is nonzero.
REQ-025 When the block is not granting, every dn_out/dt_out slice SHALL be 0, and slices other than the granted one SHALL be 0.
REQ-026 With RR_MODE=0, the block SHALL grant the lowest-index eligible counter.
REQ-027 With RR_MODE=1, the block SHALL grant the first eligible counter at index last+1, last+2, ... modulo NUM_CNT, where last is the previously granted index.
REQ-028 The round-robin pointer SHALL update only on a grant and SHALL wrap from NUM_CNT-1 to 0.
REQ-029 The block SHALL never grant while empty=1, and a change of empty during HOLD SHALL be ignored until IDLE.
REQ-030 open_in and busy_in changes during HOLD SHALL have no effect; eligibility is evaluated only in IDLE.
REQ-031 When all counters are ineligible, the block SHALL remain in IDLE indefinitely with no pulses.

Reset
REQ-032 On rst=1, the block SHALL asynchronously and immediately drive re_out=0, ld_out=0, dn_out=0 and dt_out=0, set state to IDLE, and set the round-robin last index to NUM_CNT-1 so that counter 0 is tried first.
REQ-033 A reset asserted in HOLD or during a pulse SHALL abort the pulse, and the first possible grant SHALL be sampled on the first rising edge after rst deasserts.

Configuration
REQ-034 With macro DISPATCH_STATS_EN defined, the block SHALL add output grant_cnt, 16 bits, which increments by 1 on each grant cycle, saturates at 16'hFFFF, and resets to 0.
REQ-035 Without DISPATCH_STATS_EN, the grant_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Fixed priority: RR_MODE=0, busy_in=3'b000, open_in=3'b111, empty=0, qn=5, qt=9 -> next cycle re_out=1, ld_out=3'b001, dn slice0=5, dt slice0=9, then one quiet cycle.
REQ-037 Skip busy and closed counters: busy_in=3'b001, open_in=3'b101 -> ld_out=3'b100; with open_in=3'b001 instead -> no pulse for 10 cycles.
REQ-038 Round-robin: RR_MODE=1, all eligible, empty held 0 -> successive grants 001, 010, 100, 001 spaced 2 cycles apart.
REQ-039 Empty gating: empty=1 with all counters free -> re_out=0 for 10 cycles; on empty dropping to 0 -> grant on the next cycle.
REQ-040 Reset mid-pulse: assert rst during the re_out=1 cycle -> outputs go to 0 immediately, and after release the RR pointer restarts at counter 0.
REQ-041 Stats: with DISPATCH_STATS_EN, 7 grants -> grant_cnt=7, and reset -> 0.
